se_arbiter: RTL and testbench

SE_ARBITER -- requirements
Module: se_arbiter

---
 rtl/se_arb_pkg.sv | 17 +
 rtl/se_arb_rr.sv | 10 +
 rtl/se_arbiter.sv | 167 ++++++++++++++++
 tb/tb_se_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/se_arb_pkg.sv
// se_arb_pkg: shared types and default widths for the SE arbiter.
// Contents: FSM state enum, default DATA/INST/LAT widths, request payload struct.
package se_arb_pkg;
    localparam int DATA_W_DEF = 128;
    localparam int INST_W_DEF = 8;
    localparam int LAT_W_DEF  = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    // Sized with the default widths; the arbiter is built with these defaults.
    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
        logic [DATA_W_DEF-1:0] cond;
    } payload_t;
endpackage

// File: rtl/se_arb_rr.sv
// se_arb_rr: 2-way round-robin grant.
// Ports: valid_i[1:0] requests, last_i id granted last, grant_o winning id
// (a lone requester always wins; a tie goes to the one not granted last).
module se_arb_rr (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       grant_o
);
    assign grant_o = (&valid_i) ? ~last_i : valid_i[1];
endmodule

// File: rtl/se_arbiter.sv
// se_arbiter: arbitrates two requesters onto one SE datapath, one transaction in flight.
// Ports: clk_i/rst_ni (async active-low), req_* request handshake + payload per requester,
// rsp_* response handshake with shared rsp_result_o, se_* SE input/output handshakes,
// grant_id_o in-flight owner, busy_o non-IDLE, last_lat_o/lat_differ_o latency monitor.
// Optional latency monitor enabled by defining SE_ARB_LAT_MON_EN.
module se_arbiter
    import se_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int LAT_W  = LAT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*INST_W-1:0] req_inst_i,
    input  logic [2*DATA_W-1:0] req_op1_i,
    input  logic [2*DATA_W-1:0] req_op2_i,
    input  logic [2*DATA_W-1:0] req_cond_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_result_o,
    output logic [INST_W-1:0]   se_inst_o,
    output logic [DATA_W-1:0]   se_op1_o,
    output logic [DATA_W-1:0]   se_op2_o,
    output logic [DATA_W-1:0]   se_cond_o,
    output logic                se_in_valid_o,
    input  logic                se_in_ready_i,
    input  logic [DATA_W-1:0]   se_out_result_i,
    input  logic                se_out_valid_i,
    output logic                se_out_ready_o,
    output logic                grant_id_o,
    output logic                busy_o,
    output logic [LAT_W-1:0]    last_lat_o,
    output logic                lat_differ_o
);
    state_e             state_q, state_d;
    payload_t           pay_q, pay_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               gid_q, gid_d;
    // Set when requester 0 was granted last; reset value 0 treats requester 1 as last.
    logic               last0_q, last0_d;
    logic               gnt;

    se_arb_rr u_rr (
        .valid_i (req_valid_i),
        .last_i  (~last0_q),
        .grant_o (gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pay_q   <= '0;
            res_q   <= '0;
            gid_q   <= 1'b0;
            last0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            res_q   <= res_d;
            gid_q   <= gid_d;
            last0_q <= last0_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pay_d          = pay_q;
        res_d          = res_q;
        gid_d          = gid_q;
        last0_d        = last0_q;
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        se_in_valid_o  = 1'b0;
        se_out_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o[gnt] = req_valid_i[gnt];
                if (req_valid_i[gnt]) begin
                    state_d = ISSUE;
                    gid_d   = gnt;
                    pay_d   = '{inst: gnt ? req_inst_i[2*INST_W-1:INST_W] : req_inst_i[INST_W-1:0],
                                op1:  gnt ? req_op1_i[2*DATA_W-1:DATA_W]  : req_op1_i[DATA_W-1:0],
                                op2:  gnt ? req_op2_i[2*DATA_W-1:DATA_W]  : req_op2_i[DATA_W-1:0],
                                cond: gnt ? req_cond_i[2*DATA_W-1:DATA_W] : req_cond_i[DATA_W-1:0]};
                end
            end
            ISSUE: begin
                se_in_valid_o = 1'b1;
                if (se_in_ready_i) state_d = WAIT;
            end
            WAIT: begin
                se_out_ready_o = 1'b1;
                if (se_out_valid_i) begin
                    res_d   = se_out_result_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[gid_q] = 1'b1;
                if (rsp_ready_i[gid_q]) begin
                    state_d = IDLE;
                    last0_d = ~gid_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign se_inst_o    = pay_q.inst;
    assign se_op1_o     = pay_q.op1;
    assign se_op2_o     = pay_q.op2;
    assign se_cond_o    = pay_q.cond;
    assign rsp_result_o = res_q;
    assign grant_id_o   = gid_q;
    assign busy_o       = (state_q != IDLE);

`ifdef SE_ARB_LAT_MON_EN
    logic [LAT_W-1:0]       cnt_q, cnt_d, cnt_inc, last_q, last_d;
    logic [1:0][LAT_W-1:0]  lat_q, lat_d;
    logic [1:0]             has_q, has_d;
    logic                   differ_q, differ_d;

    // Value counted so far including the current WAIT cycle, saturating.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            last_q   <= '0;
            lat_q    <= '0;
            has_q    <= '0;
            differ_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            lat_q    <= lat_d;
            has_q    <= has_d;
            differ_q <= differ_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        lat_d    = lat_q;
        has_d    = has_q;
        differ_d = differ_q;
        if (state_q == ISSUE && se_in_ready_i) cnt_d = '0;
        else if (state_q == WAIT) cnt_d = cnt_inc;
        if (state_q == WAIT && se_out_valid_i) begin
            last_d         = cnt_inc;
            lat_d[gid_q]   = cnt_inc;
            has_d[gid_q]   = 1'b1;
            if (has_q[~gid_q] && lat_q[~gid_q] != cnt_inc) differ_d = 1'b1;
        end
    end

    assign last_lat_o   = last_q;
    assign lat_differ_o = differ_q;
`else
    assign last_lat_o   = '0;
    assign lat_differ_o = 1'b0;
`endif
endmodule

// File: tb/tb_se_arbiter.sv
// tb_se_arbiter: directed self-checking bench for se_arbiter.
module tb_se_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0]  req_inst;
    logic [255:0] req_op1, req_op2, req_cond;
    logic [127:0] rsp_result, se_op1, se_op2, se_cond, se_out_result;
    logic [7:0]   se_inst, last_lat;
    logic         se_in_valid, se_in_ready, se_out_valid, se_out_ready;
    logic         grant_id, busy, lat_differ;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    se_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_inst_i(req_inst), .req_op1_i(req_op1), .req_op2_i(req_op2), .req_cond_i(req_cond),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .se_inst_o(se_inst), .se_op1_o(se_op1), .se_op2_o(se_op2), .se_cond_o(se_cond),
        .se_in_valid_o(se_in_valid), .se_in_ready_i(se_in_ready),
        .se_out_result_i(se_out_result), .se_out_valid_i(se_out_valid), .se_out_ready_o(se_out_ready),
        .grant_id_o(grant_id), .busy_o(busy), .last_lat_o(last_lat), .lat_differ_o(lat_differ)
    );

    task automatic clear_inputs;
        req_valid = '0; rsp_ready = '0; req_inst = '0; req_op1 = '0; req_op2 = '0; req_cond = '0;
        se_in_ready = 1'b0; se_out_valid = 1'b0; se_out_result = '0;
    endtask

    task automatic set_payload(input int id, input logic [7:0] inst, input logic [127:0] o1, o2, cnd);
        req_inst[id*8 +: 8] = inst;
        req_op1[id*128 +: 128] = o1;
        req_op2[id*128 +: 128] = o2;
        req_cond[id*128 +: 128] = cnd;
    endtask

    // Full transaction: SE accepts at once, WAIT lasts lat cycles, owner acks at once.
    task automatic txn(input int id, input int lat, input logic [127:0] res);
        @(negedge clk);
        set_payload(id, 8'h10, 128'(id + 1), 128'h2, 128'h3);
        req_valid = 2'(1 << id); se_in_ready = 1'b1; rsp_ready = '0; se_out_valid = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        for (int k = 1; k <= lat; k++) begin
            se_out_valid = (k == lat); se_out_result = res;
            @(negedge clk);
        end
        se_out_valid = 1'b0; rsp_ready = 2'(1 << id);
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        n_cmp++; if ({se_in_valid, se_out_ready, grant_id} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b want 000", {se_in_valid, se_out_ready, grant_id}); end
        n_cmp++; if ({se_op1, rsp_result} !== 256'h0) begin n_err++; $display("FAIL reset_regs got %0h want 0", {se_op1, rsp_result}); end
        n_cmp++; if ({last_lat, lat_differ} !== 9'h0) begin n_err++; $display("FAIL reset_mon got %0h want 0", {last_lat, lat_differ}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    endtask

    task automatic test_spurious;
        @(negedge clk);
        se_out_valid = 1'b1; se_out_result = 128'hDEAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if ({se_out_ready, rsp_valid, busy} !== 4'b0000) begin n_err++; $display("FAIL spurious_c%0d got %b want 0000", c, {se_out_ready, rsp_valid, busy}); end
            @(negedge clk);
        end
        se_out_valid = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        set_payload(0, 8'h01, 128'd5, 128'd7, 128'd0);
        req_valid = 2'b01; se_in_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_req_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if ({se_in_valid, se_inst, se_op1[7:0], se_op2[7:0], grant_id, busy} !== {1'b1, 8'h01, 8'd5, 8'd7, 1'b0, 1'b1})
            begin n_err++; $display("FAIL single_issue got %b/%0h/%0d/%0d/%b/%b want 1/1/5/7/0/1", se_in_valid, se_inst, se_op1, se_op2, grant_id, busy); end
        @(negedge clk);
        n_cmp++; if ({se_out_ready, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL single_wait got %b want 100", {se_out_ready, rsp_valid}); end
        se_out_valid = 1'b1; se_out_result = 128'd12;
        @(negedge clk);
        se_out_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_result !== 128'd12) begin n_err++; $display("FAIL single_rsp_result got %0d want 12", rsp_result); end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++; if ({busy, rsp_valid} !== 3'b000) begin n_err++; $display("FAIL single_done got %b want 000", {busy, rsp_valid}); end
    endtask

    task automatic test_contention;
        logic [1:0] got [4];
        logic [1:0] exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int k = 0;
        clear_inputs();
        rst_n = 1'b0;
        req_valid = 2'b11; se_in_ready = 1'b1; se_out_valid = 1'b1; se_out_result = 128'h77; rsp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 && k < 4) begin got[k] = rsp_valid; k++; end
        end
        clear_inputs();
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL contention_count got %0d want 4", k); end
        for (int i = 0; i < k; i++) begin
            n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL contention_order%0d got %b want %b", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_backpressure;
        int xfers = 0;
        @(negedge clk);
        set_payload(0, 8'h22, 128'hAA, 128'hBB, 128'hCC);
        req_valid = 2'b01; se_in_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({se_in_valid, se_inst, se_op1[7:0], se_op2[7:0], se_cond[7:0]} !== {1'b1, 8'h22, 8'hAA, 8'hBB, 8'hCC})
                begin n_err++; $display("FAIL bp_issue%0d got %b/%0h/%0h/%0h/%0h want 1/22/aa/bb/cc", i, se_in_valid, se_inst, se_op1, se_op2, se_cond); end
            @(negedge clk);
        end
        se_in_ready = 1'b1;
        @(negedge clk);
        se_in_ready = 1'b0; se_out_valid = 1'b1; se_out_result = 128'h1234;
        @(negedge clk);
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            se_out_result = 128'(32'hBAD0 + i);
            #1;
            n_cmp++; if ({rsp_valid, rsp_result[15:0]} !== {2'b01, 16'h1234}) begin n_err++; $display("FAIL bp_resp%0d got %b/%0h want 01/1234", i, rsp_valid, rsp_result); end
            if (|(rsp_valid & rsp_ready)) xfers++;
            @(negedge clk);
        end
        se_out_valid = 1'b0; rsp_ready = 2'b01;
        #1;
        if (|(rsp_valid & rsp_ready)) xfers++;
        @(negedge clk);
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (|(rsp_valid & rsp_ready)) xfers++;
            @(negedge clk);
        end
        rsp_ready = 2'b00;
        n_cmp++; if (xfers !== 1) begin n_err++; $display("FAIL bp_xfers got %0d want 1", xfers); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got %0b want 0", busy); end
    endtask

    task automatic test_reset_wait;
        @(negedge clk);
        set_payload(1, 8'h33, 128'h11, 128'h22, 128'h0);
        req_valid = 2'b10; se_in_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (se_out_ready !== 1'b1) begin n_err++; $display("FAIL rw_in_wait got %0b want 1", se_out_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, rsp_valid, se_in_valid, se_out_ready, req_ready, grant_id} !== 8'h0)
            begin n_err++; $display("FAIL rw_async got %b want 00000000", {busy, rsp_valid, se_in_valid, se_out_ready, req_ready, grant_id}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rw_regrant got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if ({grant_id, se_in_valid, se_inst} !== {1'b1, 1'b1, 8'h33}) begin n_err++; $display("FAIL rw_issue got %b/%b/%0h want 1/1/33", grant_id, se_in_valid, se_inst); end
        @(negedge clk);
        se_out_valid = 1'b1; se_out_result = 128'h55;
        @(negedge clk);
        se_out_valid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_result[7:0]} !== {2'b10, 8'h55}) begin n_err++; $display("FAIL rw_resp got %b/%0h want 10/55", rsp_valid, rsp_result); end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rw_done got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_payload(0, 8'h44, 128'h1, 128'h1, 128'h1);
        req_valid = 2'b01; se_in_ready = 1'b1; se_out_valid = 1'b1; se_out_result = 128'h9; rsp_ready = 2'b01;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++; if (busy !== ((c % 4) != 0)) begin n_err++; $display("FAIL b2b_busy_c%0d got %0b want %0b", c, busy, (c % 4) != 0); end
            if (c < 7) @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_monitor;
`ifdef SE_ARB_LAT_MON_EN
        txn(0, 2, 128'hA);
        n_cmp++; if ({last_lat, lat_differ} !== {8'd2, 1'b0}) begin n_err++; $display("FAIL mon_first got %0d/%0b want 2/0", last_lat, lat_differ); end
        txn(1, 5, 128'hB);
        n_cmp++; if ({last_lat, lat_differ} !== {8'd5, 1'b1}) begin n_err++; $display("FAIL mon_differ got %0d/%0b want 5/1", last_lat, lat_differ); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 3, 128'hC);
        txn(1, 3, 128'hD);
        n_cmp++; if ({last_lat, lat_differ} !== {8'd3, 1'b0}) begin n_err++; $display("FAIL mon_equal got %0d/%0b want 3/0", last_lat, lat_differ); end
`else
        txn(0, 2, 128'hA);
        txn(1, 5, 128'hB);
        n_cmp++; if ({last_lat, lat_differ} !== 9'h0) begin n_err++; $display("FAIL mon_tied got %0d/%0b want 0/0", last_lat, lat_differ); end
`endif
    endtask

    initial begin
        test_reset();
        test_spurious();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        test_monitor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
